// File: rtl/corevx_mem_arbiter_pkg.sv
// Shared definitions for the two-master memory bus arbiter: widths, response codes,
// the arbiter state encoding and the burst-length clamp.
package corevx_defs;

  localparam int ADDR_W  = 34;
  localparam int BURST_W = 5;
  localparam int DATA_W  = 32;
  localparam int BE_W    = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_CMD,
    ARB_RDATA,
    ARB_WDATA
  } arb_state_t;

  // A burstcount of zero still moves one beat; oversized bursts are counted as max_beats.
  function automatic logic [BURST_W-1:0] burst_beats(input logic [BURST_W-1:0] bc,
                                                     input logic [BURST_W-1:0] max_beats);
    if (bc == '0) begin
      return BURST_W'(1);
    end else if (bc > max_beats) begin
      return max_beats;
    end else begin
      return bc;
    end
  endfunction

endpackage

// File: rtl/corevx_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to whoever did not win last.
module corevx_rr_arbiter2 (
  input  logic req0,
  input  logic req1,
  input  logic last_winner,
  output logic any_req,
  output logic pick
);

  assign any_req = req0 | req1;
  assign pick    = (req0 && req1) ? ~last_winner : req1;

endmodule

// File: rtl/corevx_mem_arbiter.sv
// Arbitrates the instruction cache (m0) and data cache (m1) onto the single memory bus,
// holding each grant until the whole read or write burst has completed.
module corevx_mem_arbiter
  import corevx_defs::*;
#(
  parameter int MAX_BURST  = 16,
  parameter int RESET_PRIO = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  m0_address,
  input  logic [BURST_W-1:0] m0_burstcount,
  input  logic               m0_read,
  input  logic               m0_write,
  input  logic [DATA_W-1:0]  m0_writedata,
  input  logic [BE_W-1:0]    m0_byteenable,
  output logic               m0_waitrequest,
  output logic               m0_readdatavalid,
  output logic [DATA_W-1:0]  m0_readdata,
  output logic [1:0]         m0_response,
  input  logic [ADDR_W-1:0]  m1_address,
  input  logic [BURST_W-1:0] m1_burstcount,
  input  logic               m1_read,
  input  logic               m1_write,
  input  logic [DATA_W-1:0]  m1_writedata,
  input  logic [BE_W-1:0]    m1_byteenable,
  output logic               m1_waitrequest,
  output logic               m1_readdatavalid,
  output logic [DATA_W-1:0]  m1_readdata,
  output logic [1:0]         m1_response,
  output logic [ADDR_W-1:0]  s_address,
  output logic [BURST_W-1:0] s_burstcount,
  output logic               s_read,
  output logic               s_write,
  output logic [DATA_W-1:0]  s_writedata,
  output logic [BE_W-1:0]    s_byteenable,
  input  logic               s_waitrequest,
  input  logic               s_readdatavalid,
  input  logic [DATA_W-1:0]  s_readdata,
  input  logic [1:0]         s_response
);

  localparam logic [BURST_W-1:0] MAX_BEATS = BURST_W'(MAX_BURST);
  localparam logic               RESET_LW  = (RESET_PRIO == 0) ? 1'b1 : 1'b0;

  arb_state_t         state;
  logic               grant;
  logic               last_winner;
  logic [BURST_W-1:0] beats;
  logic [BURST_W-1:0] count;
  logic [BURST_W-1:0] count_inc;
  logic [BURST_W-1:0] cmd_beats;

  logic any_req;
  logic pick;

  logic               gm_read;
  logic               gm_write;
  logic [BURST_W-1:0] gm_burstcount;
  logic               pass_phase;
  logic               rd_accept;
  logic               wr_accept;
  logic               rd_beat;

  logic [1:0]             m_wait;
  logic [1:0]             m_rdv;
  logic [1:0][DATA_W-1:0] m_rdata;
  logic [1:0][1:0]        m_resp;

  corevx_rr_arbiter2 u_rr (
    .req0        (m0_read | m0_write),
    .req1        (m1_read | m1_write),
    .last_winner (last_winner),
    .any_req     (any_req),
    .pick        (pick)
  );

  assign gm_read       = grant ? m1_read       : m0_read;
  assign gm_write      = grant ? m1_write      : m0_write;
  assign gm_burstcount = grant ? m1_burstcount : m0_burstcount;

  assign s_address    = grant ? m1_address    : m0_address;
  assign s_burstcount = gm_burstcount;
  assign s_writedata  = grant ? m1_writedata  : m0_writedata;
  assign s_byteenable = grant ? m1_byteenable : m0_byteenable;

  // A read command masks a simultaneous write; only writes pass once the burst is in WDATA.
  assign pass_phase = (state == ARB_CMD) || (state == ARB_WDATA);
  assign s_read     = (state == ARB_CMD) && gm_read;
  assign s_write    = pass_phase && gm_write && !s_read;

  assign rd_accept = s_read && !s_waitrequest;
  assign wr_accept = s_write && !s_waitrequest;
  assign rd_beat   = (state == ARB_RDATA) && s_readdatavalid;
  assign count_inc = count + BURST_W'(1);
  assign cmd_beats = burst_beats(gm_burstcount, MAX_BEATS);

  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    logic mine;
    assign mine        = (grant == 1'(gi));
    assign m_wait[gi]  = (pass_phase && mine) ? s_waitrequest : 1'b1;
    assign m_rdv[gi]   = rd_beat && mine;
    assign m_rdata[gi] = m_rdv[gi] ? s_readdata : '0;
    assign m_resp[gi]  = (m_rdv[gi] || (wr_accept && mine)) ? s_response : RESP_ERROR;
  end

  assign m0_waitrequest   = m_wait[0];
  assign m0_readdatavalid = m_rdv[0];
  assign m0_readdata      = m_rdata[0];
  assign m0_response      = m_resp[0];
  assign m1_waitrequest   = m_wait[1];
  assign m1_readdatavalid = m_rdv[1];
  assign m1_readdata      = m_rdata[1];
  assign m1_response      = m_resp[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ARB_IDLE;
      grant       <= 1'b0;
      last_winner <= RESET_LW;
      beats       <= '0;
      count       <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            grant <= pick;
            state <= ARB_CMD;
          end
        end
        ARB_CMD: begin
          if (rd_accept) begin
            beats <= cmd_beats;
            count <= '0;
            state <= ARB_RDATA;
          end else if (wr_accept) begin
            beats <= cmd_beats;
            count <= BURST_W'(1);
            if (cmd_beats == BURST_W'(1)) begin
              state       <= ARB_IDLE;
              last_winner <= grant;
            end else begin
              state <= ARB_WDATA;
            end
          end
        end
        ARB_RDATA: begin
          if (s_readdatavalid) begin
            count <= count_inc;
            if (count_inc == beats) begin
              state       <= ARB_IDLE;
              last_winner <= grant;
            end
          end
        end
        ARB_WDATA: begin
          if (wr_accept) begin
            count <= count_inc;
            if (count_inc == beats) begin
              state       <= ARB_IDLE;
              last_winner <= grant;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_corevx_mem_arbiter.sv
// Bench for corevx_mem_arbiter: behavioural memory slave, two master drivers and a
// transaction-level reference (word image, grant order, fairness, per-beat responses).
module tb_corevx_mem_arbiter;

  localparam int TMO = 300;
  typedef logic [31:0] word_arr_t [16];
  typedef logic [3:0]  be_arr_t   [16];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [33:0] m_address    [2];
  logic [4:0]  m_burstcount [2];
  logic        m_read       [2];
  logic        m_write      [2];
  logic [31:0] m_writedata  [2];
  logic [3:0]  m_byteenable [2];
  logic        m_waitrequest   [2];
  logic        m_readdatavalid [2];
  logic [31:0] m_readdata      [2];
  logic [1:0]  m_response      [2];

  logic [33:0] s_address;
  logic [4:0]  s_burstcount;
  logic        s_read, s_write;
  logic [31:0] s_writedata;
  logic [3:0]  s_byteenable;
  logic        s_waitrequest, s_readdatavalid;
  logic [31:0] s_readdata;
  logic [1:0]  s_response;

  logic        m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [1:0]  m0_response, m1_response;

  assign m_waitrequest[0]   = m0_waitrequest;
  assign m_readdatavalid[0] = m0_readdatavalid;
  assign m_readdata[0]      = m0_readdata;
  assign m_response[0]      = m0_response;
  assign m_waitrequest[1]   = m1_waitrequest;
  assign m_readdatavalid[1] = m1_readdatavalid;
  assign m_readdata[1]      = m1_readdata;
  assign m_response[1]      = m1_response;

  corevx_mem_arbiter #(.MAX_BURST(16), .RESET_PRIO(1)) dut (
    .clk              (clk),
    .rst              (rst),
    .m0_address       (m_address[0]),
    .m0_burstcount    (m_burstcount[0]),
    .m0_read          (m_read[0]),
    .m0_write         (m_write[0]),
    .m0_writedata     (m_writedata[0]),
    .m0_byteenable    (m_byteenable[0]),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdatavalid (m0_readdatavalid),
    .m0_readdata      (m0_readdata),
    .m0_response      (m0_response),
    .m1_address       (m_address[1]),
    .m1_burstcount    (m_burstcount[1]),
    .m1_read          (m_read[1]),
    .m1_write         (m_write[1]),
    .m1_writedata     (m_writedata[1]),
    .m1_byteenable    (m_byteenable[1]),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdatavalid (m1_readdatavalid),
    .m1_readdata      (m1_readdata),
    .m1_response      (m1_response),
    .s_address        (s_address),
    .s_burstcount     (s_burstcount),
    .s_read           (s_read),
    .s_write          (s_write),
    .s_writedata      (s_writedata),
    .s_byteenable     (s_byteenable),
    .s_waitrequest    (s_waitrequest),
    .s_readdatavalid  (s_readdatavalid),
    .s_readdata       (s_readdata),
    .s_response       (s_response)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference state: word image as the masters intend it, grant order, event cycles.
  logic [31:0] mem     [2048];
  logic [31:0] ref_mem [2048];
  int          grant_log[$];
  int          accept_cyc  [2];
  int          last_beat_cyc [2];
  int          wr_done_cyc [2];
  logic        rd_active [2];
  int          cyc = 0;
  int unsigned wait_pct  = 0;
  int unsigned valid_pct = 100;
  logic [33:0] err_addr  = 34'h3_FFFF_FFFC;
  logic [33:0] rd_q[$];
  int          wr_left = 0;
  logic [33:0] wr_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int widx(input logic [33:0] a);
    return int'(a[12:2]);
  endfunction

  function automatic int beats_of(input logic [4:0] bc);
    if (bc == 5'd0) return 1;
    if (bc > 5'd16) return 16;
    return int'(bc);
  endfunction

  function automatic logic [1:0] resp_of(input logic [33:0] a);
    return (a == err_addr) ? 2'b11 : 2'b00;
  endfunction

  // Memory slave: samples at negedge, drives just after posedge.
  initial begin
    s_waitrequest = 1'b1; s_readdatavalid = 1'b0; s_readdata = '0; s_response = '0;
    forever begin
      @(negedge clk);
      if (s_readdatavalid) void'(rd_q.pop_front());
      if (s_read && !s_waitrequest)
        for (int i = 0; i < beats_of(s_burstcount); i++) rd_q.push_back(s_address + 34'(4 * i));
      if (s_write && !s_waitrequest) begin
        if (wr_left == 0) begin wr_left = beats_of(s_burstcount); wr_addr = s_address; end
        for (int b = 0; b < 4; b++)
          if (s_byteenable[b]) mem[widx(wr_addr)][8*b +: 8] = s_writedata[8*b +: 8];
        wr_addr = wr_addr + 34'd4;
        wr_left--;
      end
      @(posedge clk); #1;
      s_waitrequest = ($urandom_range(99) < wait_pct);
      if (rd_q.size() > 0 && $urandom_range(99) < valid_pct) begin
        s_readdatavalid = 1'b1;
        s_readdata      = mem[widx(rd_q[0])];
        s_response      = resp_of(rd_q[0]);
      end else begin
        s_readdatavalid = 1'b0;
        s_readdata      = $urandom;
        s_response      = 2'($urandom);
      end
    end
  end

  // A master with no read outstanding must never see a read beat.
  initial forever begin
    @(negedge clk);
    for (int m = 0; m < 2; m++)
      if (!rd_active[m]) chk($sformatf("stray_rdv_m%0d", m), 64'(m_readdatavalid[m]), 64'd0);
  end

  task automatic do_read(input int m, input logic [33:0] addr, input logic [4:0] bc,
                         output int waited);
    int n, t, log_at;
    n = beats_of(bc);
    @(posedge clk); #1;
    rd_active[m] = 1'b1;
    m_address[m] = addr; m_burstcount[m] = bc; m_read[m] = 1'b1;
    log_at = grant_log.size();
    waited = 0;
    @(negedge clk);
    while (m_waitrequest[m] && waited < TMO) begin waited++; @(negedge clk); end
    chk($sformatf("rd_accept_m%0d", m), 64'(m_waitrequest[m]), 64'd0);
    chk($sformatf("rd_fair_m%0d", m), 64'(grant_log.size() - log_at <= 1), 64'd1);
    grant_log.push_back(m);
    accept_cyc[m] = cyc;
    @(posedge clk); #1;
    m_read[m] = 1'b0;
    for (int i = 0; i < n; i++) begin
      t = 0;
      @(negedge clk);
      while (!m_readdatavalid[m] && t < TMO) begin t++; @(negedge clk); end
      chk($sformatf("rd_beat_m%0d_%0d", m, i), 64'(m_readdatavalid[m]), 64'd1);
      chk($sformatf("rd_data_m%0d_%0d", m, i), 64'(m_readdata[m]), 64'(ref_mem[widx(addr + 34'(4 * i))]));
      chk($sformatf("rd_resp_m%0d_%0d", m, i), 64'(m_response[m]), 64'(resp_of(addr + 34'(4 * i))));
    end
    last_beat_cyc[m] = cyc;
    rd_active[m] = 1'b0;
  endtask

  task automatic do_write(input int m, input logic [33:0] addr, input logic [4:0] bc,
                          input word_arr_t wd, input be_arr_t wbe);
    int n, t, log_at;
    n = beats_of(bc);
    @(posedge clk); #1;
    m_address[m] = addr; m_burstcount[m] = bc; m_write[m] = 1'b1;
    m_writedata[m] = wd[0]; m_byteenable[m] = wbe[0];
    log_at = grant_log.size();
    for (int i = 0; i < n; i++) begin
      t = 0;
      @(negedge clk);
      while (m_waitrequest[m] && t < TMO) begin t++; @(negedge clk); end
      chk($sformatf("wr_accept_m%0d_%0d", m, i), 64'(m_waitrequest[m]), 64'd0);
      if (i == 0) begin
        chk($sformatf("wr_fair_m%0d", m), 64'(grant_log.size() - log_at <= 1), 64'd1);
        grant_log.push_back(m);
        accept_cyc[m] = cyc;
      end
      chk($sformatf("wr_resp_m%0d_%0d", m, i), 64'(m_response[m]), 64'(s_response));
      for (int b = 0; b < 4; b++)
        if (wbe[i][b]) ref_mem[widx(addr + 34'(4 * i))][8*b +: 8] = wd[i][8*b +: 8];
      @(posedge clk); #1;
      if (i + 1 < n) begin m_writedata[m] = wd[i+1]; m_byteenable[m] = wbe[i+1]; end
      else m_write[m] = 1'b0;
    end
    wr_done_cyc[m] = cyc;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s_wait_m%0d", tag, m), 64'(m_waitrequest[m]), 64'd1);
      chk($sformatf("%s_rdv_m%0d", tag, m), 64'(m_readdatavalid[m]), 64'd0);
      chk($sformatf("%s_resp_m%0d", tag, m), 64'(m_response[m]), 64'd3);
      chk($sformatf("%s_rdata_m%0d", tag, m), 64'(m_readdata[m]), 64'd0);
    end
    chk($sformatf("%s_s_read", tag), 64'(s_read), 64'd0);
    chk($sformatf("%s_s_write", tag), 64'(s_write), 64'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  int        w0, w1, base, t, beats, bad;
  word_arr_t wd;
  be_arr_t   wbe;
  logic [31:0] old_word;

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_address[m] = '0; m_burstcount[m] = '0; m_read[m] = 1'b0; m_write[m] = 1'b0;
      m_writedata[m] = '0; m_byteenable[m] = '0; rd_active[m] = 1'b0;
    end
    for (int i = 0; i < 2048; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    mem[1] = 32'hBEAF_DEAD; ref_mem[1] = 32'hBEAF_DEAD;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // 1: single-beat read by m1; arbitration holds waitrequest high for exactly one sample.
    do_read(1, 34'h0_0000_0004, 5'd1, w1);
    chk("t1_wait_cycles", 64'(w1), 64'd1);

    // 2: simultaneous 16-beat reads after reset, m1 first, m0 only after m1's last beat.
    pulse_reset();
    base = grant_log.size();
    fork
      do_read(0, 34'h0_0000_0100, 5'd16, w0);
      do_read(1, 34'h0_0000_0200, 5'd16, w1);
    join
    chk("t2_first_grant", 64'(grant_log[base]), 64'd1);
    chk("t2_second_grant", 64'(grant_log[base+1]), 64'd0);
    chk("t2_m0_after_m1", 64'(accept_cyc[0] > last_beat_cyc[1]), 64'd1);

    // 3: m0 back-to-back reads against m1 single writes alternate strictly.
    wait_pct = 20; valid_pct = 70;
    for (int i = 0; i < 16; i++) begin wd[i] = 32'hFFCC_2211; wbe[i] = 4'hF; end
    base = grant_log.size();
    fork
      begin repeat (3) do_read(0, 34'h0_0000_0300, 5'd4, w0); end
      begin
        do_write(1, 34'h0_0000_1100, 5'd1, wd, wbe);
        do_write(1, 34'h0_0000_1104, 5'd1, wd, wbe);
      end
    join
    for (int i = 0; i < 4; i++)
      chk($sformatf("t3_order_%0d", i), 64'(grant_log[base+i]), 64'((i % 2 == 0) ? 1 : 0));
    chk("t3_mem_word", 64'(mem[widx(34'h1100)]), 64'h0000_0000_FFCC_2211);

    // 4: 3-beat write with a half-word byteenable on beat 2; m0 waits for the third beat.
    wd[0] = 32'h1111_AAAA; wd[1] = 32'h2222_BBBB; wd[2] = 32'h3333_CCCC;
    wbe[0] = 4'hF; wbe[1] = 4'h3; wbe[2] = 4'hF;
    old_word = ref_mem[widx(34'h1204)];
    fork
      do_write(1, 34'h0_0000_1200, 5'd3, wd, wbe);
      begin @(posedge clk); do_read(0, 34'h0_0000_0400, 5'd2, w0); end
    join
    chk("t4_partial_word", 64'(mem[widx(34'h1204)]), 64'({old_word[31:16], 16'hBBBB}));
    chk("t4_m0_after_burst", 64'(accept_cyc[0] > wr_done_cyc[1]), 64'd1);

    // 5: error response on beat 2 is forwarded and the burst still completes.
    err_addr = 34'h0_0000_0504;
    fork
      do_read(0, 34'h0_0000_0500, 5'd4, w0);
      begin @(posedge clk); do_read(1, 34'h0_0000_1300, 5'd1, w1); end
    join
    chk("t5_release_after_b4", 64'(accept_cyc[1] > last_beat_cyc[0]), 64'd1);
    err_addr = 34'h3_FFFF_FFFC;

    // 6: reset during the read data phase; leftover slave beats must be dropped.
    wait_pct = 0; valid_pct = 100;
    @(posedge clk); #1;
    rd_active[0] = 1'b1;
    m_address[0] = 34'h0_0000_0600; m_burstcount[0] = 5'd4; m_read[0] = 1'b1;
    t = 0;
    @(negedge clk);
    while (m_waitrequest[0] && t < TMO) begin t++; @(negedge clk); end
    chk("t6_accept", 64'(m_waitrequest[0]), 64'd0);
    @(posedge clk); #1;
    m_read[0] = 1'b0;
    beats = 0; t = 0;
    while (beats < 2 && t < TMO) begin
      @(negedge clk); t++;
      if (m_readdatavalid[0]) begin
        chk($sformatf("t6_data_%0d", beats), 64'(m_readdata[0]), 64'(ref_mem[widx(34'h600 + 34'(4 * beats))]));
        beats++;
      end
    end
    chk("t6_two_beats", 64'(beats), 64'd2);
    #2 rst = 1'b1; rd_active[0] = 1'b0;
    #1 check_reset_outputs("t6_async");
    @(posedge clk); #3 rst = 1'b0;
    t = 0;
    while (rd_q.size() > 0 && t < TMO) begin @(negedge clk); t++; end
    chk("t6_slave_drained", 64'(rd_q.size()), 64'd0);
    base = grant_log.size();
    fork
      do_read(0, 34'h0_0000_0700, 5'd2, w0);
      do_read(1, 34'h0_0000_0704, 5'd3, w1);
    join
    chk("t6_regrant_prio", 64'(grant_log[base]), 64'd1);

    // Random traffic: m0 reads low region, m1 mixes reads and writes in its own region.
    wait_pct = 30; valid_pct = 60;
    fork
      for (int k = 0; k < 20; k++)
        do_read(0, 34'(32'h40 * $urandom_range(0, 59)), 5'($urandom_range(0, 20)), w0);
      for (int k = 0; k < 20; k++) begin
        if ($urandom_range(1) == 1) begin
          for (int i = 0; i < 16; i++) begin wd[i] = $urandom; wbe[i] = 4'($urandom); end
          do_write(1, 34'(32'h1000 + 32'h40 * $urandom_range(0, 59)), 5'($urandom_range(0, 20)), wd, wbe);
        end else begin
          do_read(1, 34'(32'h1000 + 32'h40 * $urandom_range(0, 59)), 5'($urandom_range(0, 20)), w1);
        end
      end
    join

    bad = 0;
    for (int i = 0; i < 2048; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("final_mem_image", 64'(bad), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/corevx_mem_arbiter.md
Name: corevx_mem_arbiter

Overview:
- Two-master to one-slave arbiter for the memory bus (address 34, burstcount 5, response 2), placed directly downstream of the caches.
- Master 0 is the instruction cache; master 1 is the data cache (corevx_cache m_* port). The slave is the system memory / PMA bus.
- Grants one master at a time, round-robin on contention. A grant holds until that master's whole transaction (read burst or write burst) completes.

Parameters:
- MAX_BURST, 16, largest legal burstcount. Values above it are clamped to MAX_BURST for beat counting.
- RESET_PRIO, 1, master that wins the first tie after reset (data cache first).

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- m0_address, m1_address  input  34 / s_address  output  34  word-aligned byte address
- m0_burstcount, m1_burstcount  input  5 / s_burstcount  output  5  beats in burst
- m0_read, m1_read  input  1 / s_read  output  1  read command
- m0_write, m1_write  input  1 / s_write  output  1  write beat
- m0_writedata, m1_writedata  input  32 / s_writedata  output  32  write data
- m0_byteenable, m1_byteenable  input  4 / s_byteenable  output  4  byte lanes
- m0_waitrequest, m1_waitrequest  output  1 / s_waitrequest  input  1  stall
- m0_readdatavalid, m1_readdatavalid  output  1 / s_readdatavalid  input  1  read beat valid
- m0_readdata, m1_readdata  output  32 / s_readdata  input  32  read data
- m0_response, m1_response  output  2 / s_response  input  2  00 OKAY, 11 error, per beat

Behaviour:
States: IDLE, CMD, RDATA, WDATA. Registered: grant (0/1), last_winner, beat counter (5 bits).

Reset values:
- state=IDLE; last_winner=~RESET_PRIO.
- s_read=s_write=0; mX_waitrequest=1; mX_readdatavalid=0; mX_response=2'b11; mX_readdata=0.

IDLE:
- All masters see waitrequest=1. s_read=s_write=0.
- Exactly one requester (read|write) -> grant it.
- Both request -> grant !last_winner.
- Go to CMD next cycle. Arbitration costs exactly one cycle.

CMD:
- Granted master's command signals pass combinationally to s_*. Its waitrequest = s_waitrequest. The other master holds waitrequest=1.
- Read accepted (s_read & !s_waitrequest): latch beats = (burstcount==0 ? 1 : min(burstcount, MAX_BURST)); go to RDATA.
- Write beat accepted (s_write & !s_waitrequest): latch beats the same way, then:
  - beats==1 -> back to IDLE, set last_winner=grant.
  - else count=1, go to WDATA.
- read & write both high in one cycle: read wins, the write is ignored.

RDATA:
- s_read=s_write=0.
- s_readdatavalid/readdata/response route to the granted master only. The other master sees readdatavalid=0.
- Each valid beat increments count. On the final beat go to IDLE and set last_winner=grant. The new grant follows on the next cycle; there is no same-cycle regrant.
- s_readdatavalid in IDLE/CMD/WDATA (stray) is dropped and not forwarded.

WDATA:
- Passthrough as in CMD, writes only. Each accepted beat increments count.
- Final beat -> IDLE, set last_winner=grant.
- Granted master deasserting write mid-burst simply stalls; no abort.

Error responses:
- s_response=11 is forwarded unchanged on the beat it arrives.
- The burst still runs to full length; the arbiter never truncates it.

Other rules:
- mX_response: forwarded when that master's beat completes, otherwise 2'b11.
- Reset asserted mid-burst forces IDLE immediately. Slave-side cleanup is the system's responsibility.
- Fairness: a master continuously requesting waits at most one full transaction of the other master.

Decomposition:
- corevx_defs package holds:
  - state enum ARB_IDLE/ARB_CMD/ARB_RDATA/ARB_WDATA;
  - response constants RESP_OKAY=2'b00, RESP_ERROR=2'b11;
  - bus width constants (ADDR 34, BURST 5).
- Sub-module corevx_rr_arbiter2 provides the combinational 2-way round-robin pick from (req0, req1, last_winner).

Test Plan:
1. m1 read, burstcount=1, addr 0x0_0000_0004, mem=BEAFDEAD -> m1_waitrequest low 2 cycles after request at the earliest; m1_readdatavalid once with BEAFDEAD; m0 sees no valid.
2. Both read in the same cycle after reset -> m1 granted first (RESET_PRIO=1); m0 granted only after m1's 16-beat burst ends, beats 0..15 in order to m1, then m0.
3. m0 continuous 4-beat reads while m1 issues single writes FFCC2211 -> strict alternation m1,m0,m1; write lands in mem with byteenable 4'b1111.
4. m1 write burst of 3 beats, byteenable 4'b0011 on beat 2 -> only low halfword updated on beat 2; m0 blocked until the third beat is accepted.
5. Slave returns response 11 on beat 2 of a 4-beat read -> that beat forwarded with 11, beats 3-4 still delivered, grant released after beat 4.
6. rst pulsed during RDATA beat 2 -> outputs return to reset values asynchronously; the next request is arbitrated from IDLE; stray remaining s_readdatavalid beats are not forwarded.
